// File: rtl/dc_fifo_pkt_commit.sv
// rtl/dc_fifo_pkt_commit.sv - dual-clock FIFO with write-side packet commit/discard
//
// Words written since the last commit stay private to the write side. A commit
// publishes them, a discard rolls them back. A publish walker advances the
// exported pointer one step per wr_clk, so the gray crossing only sees
// single-bit changes.
//
// Ports (wr_clk domain): wr_data, wr_en, wr_commit, wr_discard, full (comb),
//   almost_full (reg), wr_cnt (reg, committed + uncommitted words held)
// Ports (rd_clk domain): rd_data (FWFT head), rd_en, empty (comb),
//   almost_empty (reg), rd_cnt (reg, published words visible)
// rst_n: asynchronous active-low reset for both domains.
// Optional macro DC_FIFO_ERR_FLAG_EN adds sticky ovf_err (wr_clk) and udf_err (rd_clk).
`timescale 1ns/1ps

module dc_fifo_pkt_commit #(
    parameter int DATA_BIT    = 32,
    parameter int ADDR_BIT    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AFULL_TH    = 12,
    parameter int AEMPTY_TH   = 2
) (
    input  logic                wr_clk,
    input  logic                rst_n,
    input  logic                rd_clk,
    input  logic [DATA_BIT-1:0] wr_data,
    input  logic                wr_en,
    input  logic                wr_commit,
    input  logic                wr_discard,
    output logic                full,
    output logic                almost_full,
    output logic [ADDR_BIT:0]   wr_cnt,
    output logic [DATA_BIT-1:0] rd_data,
    input  logic                rd_en,
    output logic                empty,
    output logic                almost_empty,
    output logic [ADDR_BIT:0]   rd_cnt
`ifdef DC_FIFO_ERR_FLAG_EN
    ,
    output logic                ovf_err,
    output logic                udf_err
`endif
);

    localparam int PW    = ADDR_BIT + 1;
    localparam int DEPTH = 1 << ADDR_BIT;
    // Gray of a pointer one full lap ahead differs only in its top two bits.
    localparam logic [ADDR_BIT:0] FULL_MASK = PW'(3 << (ADDR_BIT - 1));

    function automatic logic [ADDR_BIT:0] bin2gray(input logic [ADDR_BIT:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [ADDR_BIT:0] gray2bin(input logic [ADDR_BIT:0] g);
        logic [ADDR_BIT:0] b;
        b[ADDR_BIT] = g[ADDR_BIT];
        for (int i = ADDR_BIT - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [DATA_BIT-1:0] mem [DEPTH];

    // write domain state
    logic [ADDR_BIT:0] wp_tmp, wp_cmt, wp_pub, wp_pub_gray;
    logic [ADDR_BIT:0] rp_wsync [SYNC_STAGES];
    logic [ADDR_BIT:0] wp_tmp_nxt, wp_cmt_nxt, wp_pub_nxt, wr_cnt_nxt;
    logic              wr_acc;

    // read domain state
    logic [ADDR_BIT:0] rp, rp_gray;
    logic [ADDR_BIT:0] wp_rsync [SYNC_STAGES];
    logic [ADDR_BIT:0] rp_nxt, rd_cnt_nxt;
    logic              rd_acc;

    assign full   = (bin2gray(wp_tmp) == (rp_wsync[SYNC_STAGES-1] ^ FULL_MASK));
    assign wr_acc = wr_en & ~full & ~wr_discard;

    always_comb begin
        wp_tmp_nxt = wp_tmp + PW'(wr_acc);
        wp_cmt_nxt = wp_cmt;
        if (wr_discard) begin
            // discard wins over a same-cycle commit
            wp_tmp_nxt = wp_cmt;
        end else if (wr_commit) begin
            wp_cmt_nxt = wp_tmp + PW'(wr_acc);
        end
        wp_pub_nxt = (wp_pub != wp_cmt) ? wp_pub + PW'(1) : wp_pub;
        wr_cnt_nxt = wp_tmp_nxt - gray2bin(rp_wsync[SYNC_STAGES-1]);
    end

    always_ff @(posedge wr_clk) begin
        if (wr_acc) begin
            mem[wp_tmp[ADDR_BIT-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_tmp      <= '0;
            wp_cmt      <= '0;
            wp_pub      <= '0;
            wp_pub_gray <= '0;
            wr_cnt      <= '0;
            almost_full <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                rp_wsync[i] <= '0;
            end
        end else begin
            wp_tmp      <= wp_tmp_nxt;
            wp_cmt      <= wp_cmt_nxt;
            wp_pub      <= wp_pub_nxt;
            // gray taken from the next value so the exported copy tracks wp_pub
            wp_pub_gray <= bin2gray(wp_pub_nxt);
            wr_cnt      <= wr_cnt_nxt;
            almost_full <= (wr_cnt_nxt >= PW'(AFULL_TH));
            rp_wsync[0] <= rp_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                rp_wsync[i] <= rp_wsync[i-1];
            end
        end
    end

    assign empty   = (bin2gray(rp) == wp_rsync[SYNC_STAGES-1]);
    assign rd_acc  = rd_en & ~empty;
    assign rd_data = mem[rp[ADDR_BIT-1:0]];

    always_comb begin
        rp_nxt     = rp + PW'(rd_acc);
        rd_cnt_nxt = gray2bin(wp_rsync[SYNC_STAGES-1]) - rp_nxt;
    end

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            rp           <= '0;
            rp_gray      <= '0;
            rd_cnt       <= '0;
            almost_empty <= 1'b1;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                wp_rsync[i] <= '0;
            end
        end else begin
            rp           <= rp_nxt;
            rp_gray      <= bin2gray(rp_nxt);
            rd_cnt       <= rd_cnt_nxt;
            almost_empty <= (rd_cnt_nxt <= PW'(AEMPTY_TH));
            wp_rsync[0]  <= wp_pub_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                wp_rsync[i] <= wp_rsync[i-1];
            end
        end
    end

`ifdef DC_FIFO_ERR_FLAG_EN
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_err <= 1'b0;
        end else if (wr_en & full & ~wr_discard) begin
            ovf_err <= 1'b1;
        end
    end

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            udf_err <= 1'b0;
        end else if (rd_en & empty) begin
            udf_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dc_fifo_pkt_commit.sv
// tb/tb_dc_fifo_pkt_commit.sv - scoreboard bench for dc_fifo_pkt_commit
`timescale 1ns/1ps

module tb_dc_fifo_pkt_commit;

    logic        wr_clk = 1'b0, rd_clk = 1'b0, rst_n = 1'b0;
    logic [31:0] wr_data = '0;
    logic        wr_en = 1'b0, wr_commit = 1'b0, wr_discard = 1'b0, rd_en = 1'b0;
    logic        full, almost_full, empty, almost_empty;
    logic [4:0]  wr_cnt, rd_cnt;
    logic [31:0] rd_data;
`ifdef DC_FIFO_ERR_FLAG_EN
    logic        ovf_err, udf_err;
`endif

    int wr_half = 5, rd_half = 5;
    int rd_mode = 0;            // 0 idle, 1 always read, 2 random read
    int checks = 0, failures = 0;
    logic last_acc;

    logic [31:0] pend[$];       // written but uncommitted
    logic [31:0] exp_q[$];      // committed, not yet read

    dc_fifo_pkt_commit dut (
        .wr_clk(wr_clk), .rst_n(rst_n), .rd_clk(rd_clk),
        .wr_data(wr_data), .wr_en(wr_en), .wr_commit(wr_commit), .wr_discard(wr_discard),
        .full(full), .almost_full(almost_full), .wr_cnt(wr_cnt),
        .rd_data(rd_data), .rd_en(rd_en), .empty(empty),
        .almost_empty(almost_empty), .rd_cnt(rd_cnt)
`ifdef DC_FIFO_ERR_FLAG_EN
        , .ovf_err(ovf_err), .udf_err(udf_err)
`endif
    );

    initial forever #(wr_half) wr_clk = ~wr_clk;
    initial forever #(rd_half) rd_clk = ~rd_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reader stimulus: change rd_en just after each rd_clk edge.
    initial forever begin
        @(posedge rd_clk);
        #1;
        case (rd_mode)
            1:       rd_en = 1'b1;
            2:       rd_en = 1'($urandom_range(0, 1));
            default: rd_en = 1'b0;
        endcase
    end

    // Monitor: a pop happens at the next rd_clk edge whenever rd_en & !empty.
    always @(negedge rd_clk) begin
        if (rst_n) begin
            check("rd_cnt_le_depth", 32'(rd_cnt <= 5'd16), 32'd1);
            if (rd_en && !empty) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", rd_data, 32'hxxxx_xxxx);
                end else begin
                    check("rd_data", rd_data, exp_q.pop_front());
                end
            end
        end
    end

    // One write-side cycle; the model applies the packet rules directly.
    task automatic wr_step(input logic en, input logic [31:0] d, input logic cmt, input logic disc);
        logic acc;
        wr_en = en; wr_data = d; wr_commit = cmt; wr_discard = disc;
        acc = en && !full && !disc;
        if (acc) check("no_overflow", 32'(pend.size() + exp_q.size() < 16), 32'd1);
        if (disc) begin
            pend.delete();
        end else begin
            if (acc) pend.push_back(d);
            if (cmt) while (pend.size() > 0) exp_q.push_back(pend.pop_front());
        end
        last_acc = acc;
        @(posedge wr_clk);
        #1;
        wr_en = 1'b0; wr_commit = 1'b0; wr_discard = 1'b0;
    endtask

    task automatic idle_wr(input int n);
        repeat (n) @(posedge wr_clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        rd_mode = 1;
        while ((exp_q.size() != 0 || !empty) && n < 20000) begin
            @(posedge wr_clk);
            n++;
        end
        #1;
        check("drain_in_time", 32'(n < 20000), 32'd1);
        rd_mode = 0;
        idle_wr(12);
    endtask

    initial begin
        int n, tries, len;
        logic dsc;

        #23 rst_n = 1'b1;
        @(posedge wr_clk);
        #1;
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_wr_cnt", 32'(wr_cnt), 32'd0);
        check("rst_rd_cnt", 32'(rd_cnt), 32'd0);
        check("rst_almost_empty", 32'(almost_empty), 32'd1);
        check("rst_almost_full", 32'(almost_full), 32'd0);
`ifdef DC_FIFO_ERR_FLAG_EN
        check("rst_ovf_err", 32'(ovf_err), 32'd0);
        check("rst_udf_err", 32'(udf_err), 32'd0);
`endif

        // uncommitted words stay invisible, then commit publishes them
        for (int i = 0; i < 5; i++) wr_step(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);
        repeat (20) @(posedge rd_clk);
        idle_wr(1);
        check("uncommitted_empty", 32'(empty), 32'd1);
        check("uncommitted_wr_cnt", 32'(wr_cnt), 32'd5);
        wr_step(1'b0, 32'd0, 1'b1, 1'b0);
        n = 0;
        while (rd_cnt != 5'd5 && n < 200) begin
            @(posedge wr_clk);
            n++;
        end
        #1;
        check("commit_rd_cnt_5", 32'(rd_cnt), 32'd5);
        check("commit_almost_empty", 32'(almost_empty), 32'd0);
        drain();

        // discard drops pending words; commit rides on the last write
        for (int i = 0; i < 3; i++) wr_step(1'b1, 32'hD0 + 32'(i), 1'b0, 1'b0);
        wr_step(1'b0, 32'd0, 1'b0, 1'b1);
        wr_step(1'b1, 32'hB0, 1'b0, 1'b0);
        wr_step(1'b1, 32'hB1, 1'b1, 1'b0);
        drain();
        check("discard_wr_cnt_0", 32'(wr_cnt), 32'd0);

        // fill to the boundary with the reader idle
        for (int i = 0; i < 16; i++) begin
            wr_step(1'b1, 32'hF00 + 32'(i), 1'b0, 1'b0);
            if (i == 10) check("almost_full_at_11", 32'(almost_full), 32'd0);
            if (i == 11) check("almost_full_at_12", 32'(almost_full), 32'd1);
        end
        check("full_at_16", 32'(full), 32'd1);
        check("wr_cnt_16", 32'(wr_cnt), 32'd16);
        wr_step(1'b1, 32'hDEAD, 1'b0, 1'b0);
        check("write_17_ignored", 32'(wr_cnt), 32'd16);
`ifdef DC_FIFO_ERR_FLAG_EN
        check("ovf_err_set", 32'(ovf_err), 32'd1);
`endif
        wr_step(1'b0, 32'd0, 1'b1, 1'b0);
        drain();

        // simultaneous write + commit + discard: nothing written, nothing published
        wr_step(1'b1, 32'hC0, 1'b0, 1'b0);
        wr_step(1'b1, 32'hC1, 1'b0, 1'b0);
        wr_step(1'b1, 32'hC2, 1'b1, 1'b1);
        wr_step(1'b0, 32'd0, 1'b1, 1'b0);
        rd_mode = 1;
        idle_wr(100);
        rd_mode = 0;
        check("triple_empty", 32'(empty), 32'd1);
        check("triple_rd_cnt", 32'(rd_cnt), 32'd0);
        check("triple_wr_cnt", 32'(wr_cnt), 32'd0);
`ifdef DC_FIFO_ERR_FLAG_EN
        check("udf_err_set", 32'(udf_err), 32'd1);
`endif

        // random packets at wr:rd clock ratios 1:3 and 3:1
        for (int r = 0; r < 2; r++) begin
            wr_half = (r == 0) ? 5 : 15;
            rd_half = (r == 0) ? 15 : 5;
            idle_wr(2);
            rd_mode = 2;
            for (int p = 0; p < 500; p++) begin
                len = $urandom_range(1, 8);
                dsc = ($urandom_range(0, 9) == 0);
                idle_wr($urandom_range(0, 2));
                for (int i = 0; i < len; i++) begin
                    tries = 0;
                    do begin
                        wr_step(1'b1, $urandom, (i == len - 1) && !dsc, 1'b0);
                        tries++;
                    end while (!last_acc && tries < 2000);
                    if (!last_acc) check("write_accept_timeout", 32'(tries), 32'd0);
                end
                if (dsc) wr_step(1'b0, 32'd0, 1'b0, 1'b1);
            end
            drain();
            check("random_wr_cnt_0", 32'(wr_cnt), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dc_fifo_pkt_commit.md
Name: dc_fifo_pkt_commit

Overview:
Parametrised dual-clock FIFO with packet commit/discard on the write side. Intended for input controllers that buffer a frame's info/data while its CRC is being checked. Words written since the last commit are invisible to the read side. On commit they are published; on discard they are rolled back. Gray-coded pointers cross clock domains through a configurable synchroniser depth, and occupancy counts are full-range.

Parameters:
DATA_BIT, 32, data word width
ADDR_BIT, 4, log2 of depth; depth = 2**ADDR_BIT, minimum 2
SYNC_STAGES, 2, flop stages per pointer crossing, minimum 2
AFULL_TH, 12, almost_full asserts when wr_cnt >= AFULL_TH
AEMPTY_TH, 2, almost_empty asserts when rd_cnt <= AEMPTY_TH

Ports:
wr_clk  in  1  write clock
rst_n  in  1  async active-low reset, both domains
rd_clk  in  1  read clock
wr_data  in  DATA_BIT  write word
wr_en  in  1  write request
wr_commit  in  1  publish all uncommitted words, including a same-cycle accepted write
wr_discard  in  1  drop all uncommitted words
full  out  1  wr_clk domain, combinational
almost_full  out  1  wr_clk domain, registered
wr_cnt  out  ADDR_BIT+1  words held (committed plus uncommitted), registered
rd_data  out  DATA_BIT  FWFT head word, valid while !empty
rd_en  in  1  pop head
empty  out  1  rd_clk domain, combinational
almost_empty  out  1  rd_clk domain, registered
rd_cnt  out  ADDR_BIT+1  published words visible to reader, registered

Behaviour:
- Reset: rst_n is asynchronous and active-low; the write-side clock is wr_clk. All pointers and sync flops clear to 0. Output reset values: full=0, almost_full=0, wr_cnt=0, empty=1, almost_empty=1, rd_cnt=0. Memory is not reset.
- Write pointers, ADDR_BIT+1 bits binary, wrap mod 2**(ADDR_BIT+1):
  - wp_tmp: the next write slot.
  - wp_cmt: the commit boundary.
  - wp_pub: the pointer exported to the read side.
- Accepted write = wr_en & !full & !wr_discard. It writes mem[wp_tmp[ADDR_BIT-1:0]] and increments wp_tmp.
- wr_commit:
  - Sets wp_cmt to wp_tmp, or to wp_tmp+1 when a write is accepted in the same cycle.
  - Commit with nothing pending is a no-op.
- wr_discard: sets wp_tmp to wp_cmt and ignores wr_en that cycle. If asserted together with wr_commit, discard wins and the commit is ignored.
- Publish walker (wp_pub):
  - While wp_pub != wp_cmt, wp_pub increments by exactly 1 per wr_clk.
  - Its gray code is registered and then synchronised into rd_clk through SYNC_STAGES flops.
  - The gray crossing therefore only ever sees single-bit changes.
  - Discard never moves wp_pub or wp_cmt.
- Read pointer rp:
  - Its gray code is registered and synchronised into wr_clk through SYNC_STAGES flops.
  - An accepted read is rd_en & !empty; it increments rp. rd_en while empty is ignored.
- Full/empty conditions:
  - full = gray(wp_tmp) equals rp_sync_gray with its top two bits inverted. Full is judged against the uncommitted pointer, so pending words consume space.
  - empty = gray(rp) == wp_pub_sync_gray.
- Registered counts, updated every cycle:
  - wr_cnt = wp_tmp - bin(rp_sync).
  - rd_cnt = bin(wp_pub_sync) - rp.
  - Both counts are ADDR_BIT+1 bits wide, so a full FIFO reads 2**ADDR_BIT.
- almost_full = next wr_cnt >= AFULL_TH; almost_empty = next rd_cnt <= AEMPTY_TH. Both are registered alongside the counts.
- Visibility latency: a packet of N words committed at edge t becomes fully readable no earlier than t + N wr_clk cycles, plus 1 register stage, plus SYNC_STAGES rd_clk cycles. The first word is readable after 1 wr_clk + (SYNC_STAGES+1) rd_clk.
- Back-to-back commits while the walker is still running: the walker continues toward the latest wp_cmt, and no data is lost.
- Space freed by reads is seen on the write side after SYNC_STAGES+1 wr_clk cycles; full is therefore pessimistic, never optimistic.
- Reset mid-packet: all uncommitted and committed data is lost, and outputs return to their reset values immediately.

Optional Feature:
DC_FIFO_ERR_FLAG_EN
- Defined: adds two sticky outputs, both cleared only by rst_n.
  - ovf_err (wr_clk): sets when wr_en & full & !wr_discard.
  - udf_err (rd_clk): sets when rd_en & empty.
- Undefined: these ports are absent; the same conditions are silently ignored.

Test Plan:
- Reset, then no activity: empty=1, full=0, wr_cnt=0, rd_cnt=0, almost_empty=1.
- Write 5 words 0xA0..0xA4 without commit, wait 20 rd_clk → empty stays 1 and wr_cnt=5. Then assert wr_commit → rd_cnt reaches 5 and reads return 0xA0..0xA4 in order.
- Write 3 words, wr_discard, write 2 words 0xB0,0xB1 with commit on the last → reader sees only 0xB0,0xB1, and wr_cnt settles at 0 after draining.
- Write 16 words with no reads (ADDR_BIT=4) → full=1 after the 16th, wr_cnt=16, almost_full=1 at wr_cnt=12. A 17th wr_en is ignored, and ovf_err=1 when DC_FIFO_ERR_FLAG_EN is defined.
- Clock ratios wr:rd of 1:3 and 3:1, 1000 random packets of 1..8 words, 10% discarded → reader output equals the committed stream exactly, full and empty are never violated, and rd_cnt never exceeds 16.
- Same-cycle wr_en+wr_commit+wr_discard → no word written, wp_cmt unchanged, reader sees nothing new.
